// File: rtl/wb_cmd_master_pkg.sv
// Shared types and state encoding for the Wishbone command initiator.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/wb_cmd_master_timer.sv
// Bus-cycle watchdog: clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module wb_cmd_master_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  assign tc = (count == LAST);

  // Holds at the terminal value so the counter can never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-beat initiator: one command in, one bus cycle, one response out.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int WB_ADR_WIDTH   = 37,
  parameter int WB_DAT_WIDTH   = 64,
  parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ERRCNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
  input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
  input  logic                    s_cmd_we,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_we_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i,
  output logic [WB_DAT_WIDTH-1:0] m_rsp_dat,
  output logic                    m_rsp_we,
  output logic                    m_rsp_err,
  output logic                    m_rsp_valid,
  input  logic                    m_rsp_ready,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output state_t                  dbg_state
);

  // Handshake rule for both streams: a transfer happens on a rising clk edge where
  // valid and ready are both high; a producer holds its payload stable until then.

  logic [1:0] state;
  logic       run_q;
  logic       accept;
  logic       timer_tc;

  assign s_cmd_ready = run_q && (state == ST_IDLE);
  assign accept      = s_cmd_valid && s_cmd_ready;
  assign dbg_state   = state_t'(state);

  wb_cmd_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (accept),
    .en     (state == ST_BUS),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      run_q       <= 1'b0;
      m_wb_adr_o  <= '0;
      m_wb_dat_o  <= '0;
      m_wb_sel_o  <= '0;
      m_wb_we_o   <= 1'b0;
      m_wb_stb_o  <= 1'b0;
      m_rsp_dat   <= '0;
      m_rsp_we    <= 1'b0;
      m_rsp_err   <= 1'b0;
      m_rsp_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            m_wb_adr_o <= s_cmd_adr;
            m_wb_dat_o <= s_cmd_dat;
            m_wb_sel_o <= s_cmd_sel;
            m_wb_we_o  <= s_cmd_we;
            m_wb_stb_o <= 1'b1;
            state      <= ST_BUS;
          end
        end
        ST_BUS: begin
          // ACK takes priority over a timeout landing on the same cycle.
          if (m_wb_ack_i) begin
            m_wb_stb_o  <= 1'b0;
            m_rsp_dat   <= m_wb_we_o ? '0 : m_wb_dat_i;
            m_rsp_we    <= m_wb_we_o;
            m_rsp_err   <= 1'b0;
            m_rsp_valid <= 1'b1;
            state       <= ST_RESP;
          end else if (timer_tc) begin
            m_wb_stb_o  <= 1'b0;
            m_rsp_dat   <= '0;
            m_rsp_we    <= m_wb_we_o;
            m_rsp_err   <= 1'b1;
            m_rsp_valid <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_rsp_ready) begin
            m_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed and randomized bench for wb_cmd_master with a queue-based response model.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int AW = 37;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 8;
  localparam int EW = 2;
  localparam int RW = DW + 2;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] s_cmd_adr = '0;
  logic [DW-1:0] s_cmd_dat = '0;
  logic [SW-1:0] s_cmd_sel = '0;
  logic          s_cmd_we = 1'b0;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [AW-1:0] m_wb_adr_o;
  logic [DW-1:0] m_wb_dat_o;
  logic [DW-1:0] m_wb_dat_i = '0;
  logic [SW-1:0] m_wb_sel_o;
  logic          m_wb_we_o;
  logic          m_wb_stb_o;
  logic          m_wb_ack_i = 1'b0;
  logic [DW-1:0] m_rsp_dat;
  logic          m_rsp_we;
  logic          m_rsp_err;
  logic          m_rsp_valid;
  logic          m_rsp_ready = 1'b0;
  logic [EW-1:0] err_count;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int model_errcnt = 0;
  logic [RW-1:0] exp_q[$];

  wb_cmd_master #(
    .WB_ADR_WIDTH  (AW),
    .WB_DAT_WIDTH  (DW),
    .WB_SEL_WIDTH  (SW),
    .TIMEOUT_CYCLES(TO),
    .ERRCNT_WIDTH  (EW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_cmd_adr  (s_cmd_adr),
    .s_cmd_dat  (s_cmd_dat),
    .s_cmd_sel  (s_cmd_sel),
    .s_cmd_we   (s_cmd_we),
    .s_cmd_valid(s_cmd_valid),
    .s_cmd_ready(s_cmd_ready),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_sel_o (m_wb_sel_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_ack_i (m_wb_ack_i),
    .m_rsp_dat  (m_rsp_dat),
    .m_rsp_we   (m_rsp_we),
    .m_rsp_err  (m_rsp_err),
    .m_rsp_valid(m_rsp_valid),
    .m_rsp_ready(m_rsp_ready),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a slave ACKing on stb cycle ack_delay+1 completes the cycle unless that is
  // beyond the timeout window; reads return slave data, writes and timeouts return 0.
  task automatic do_cmd(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel, input logic we, input int ack_delay,
                        input logic [DW-1:0] rdata, input int hold);
    int stb_cnt;
    int exp_stb;
    int guard;
    bit timed_out;
    logic [DW-1:0] exp_dat;
    logic [RW-1:0] exp_rsp;
    logic [RW-1:0] got_rsp;
    timed_out = (ack_delay >= TO);
    exp_stb = timed_out ? TO : ack_delay + 1;
    exp_dat = (we || timed_out) ? '0 : rdata;
    if (timed_out && model_errcnt < ERR_MAX) model_errcnt++;
    exp_q.push_back({we, timed_out, exp_dat});

    @(negedge clk);
    s_cmd_adr = adr;
    s_cmd_dat = dat;
    s_cmd_sel = sel;
    s_cmd_we = we;
    s_cmd_valid = 1'b1;
    guard = 0;
    while (!s_cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready", {127'd0, s_cmd_ready}, 128'd1);
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
    s_cmd_adr = AW'({$urandom, $urandom});
    s_cmd_dat = {$urandom, $urandom};
    s_cmd_we = ~we;

    stb_cnt = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      m_wb_ack_i = 1'b0;
      m_wb_dat_i = {$urandom, $urandom};
      if (!m_wb_stb_o) break;
      stb_cnt++;
      check("wb_fields", 128'({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o}),
            128'({adr, dat, sel, we}));
      if (stb_cnt == ack_delay + 1) begin
        m_wb_ack_i = 1'b1;
        m_wb_dat_i = rdata;
      end
    end
    check("stb_cycles", 128'(stb_cnt), 128'(exp_stb));

    exp_rsp = exp_q.pop_front();
    got_rsp = {m_rsp_we, m_rsp_err, m_rsp_dat};
    check("rsp_valid", {127'd0, m_rsp_valid}, 128'd1);
    check("rsp_fields", 128'(got_rsp), 128'(exp_rsp));
    check("err_count", 128'(err_count), 128'(model_errcnt));

    for (int h = 0; h < hold; h++) begin
      s_cmd_valid = 1'b1;
      s_cmd_adr = AW'($urandom);
      @(negedge clk);
      check("hold_rsp", 128'({m_rsp_valid, m_rsp_we, m_rsp_err, m_rsp_dat}), 128'({1'b1, exp_rsp}));
      check("hold_ready_stb", 128'({s_cmd_ready, m_wb_stb_o}), 128'd0);
    end
    m_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    m_rsp_ready = 1'b0;
    s_cmd_valid = 1'b0;
    @(negedge clk);
    check("post_hs", 128'({m_rsp_valid, m_wb_stb_o, s_cmd_ready}), 128'({1'b0, 1'b0, 1'b1}));
  endtask

  initial begin
    int guard;
    // Reset state
    #1;
    check("rst_outputs", 128'({s_cmd_ready, m_wb_stb_o, m_rsp_valid, m_rsp_err, err_count}), 128'd0);
    check("rst_state", 128'(dbg_state), 128'(IDLE));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", {127'd0, s_cmd_ready}, 128'd1);

    // Directed: write with ACK on first stb cycle, read with ACK on third
    do_cmd(37'h10, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1, 0, 64'h5555_AAAA_5555_AAAA, 0);
    do_cmd(37'h20, 64'h0, 8'h0F, 1'b0, 2, 64'h0123_4567_89AB_CDEF, 0);
    // Timeout, then ACK on the timeout cycle
    do_cmd(37'h30, 64'h1, 8'h01, 1'b0, TO + 5, 64'h1111, 0);
    do_cmd(37'h40, 64'h2, 8'h80, 1'b0, TO - 1, 64'hCAFE_F00D_1234_5678, 0);
    // Backpressured response with a competing command
    do_cmd(37'h50, 64'h3, 8'h3C, 1'b0, 1, 64'h0BAD_C0DE_0000_FFFF, 5);

    // ACK outside a cycle must be ignored
    @(negedge clk);
    m_wb_ack_i = 1'b1;
    @(negedge clk);
    m_wb_ack_i = 1'b0;
    check("idle_ack", 128'({m_wb_stb_o, m_rsp_valid, s_cmd_ready}), 128'({1'b0, 1'b0, 1'b1}));

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      do_cmd(AW'({$urandom, $urandom}), {$urandom, $urandom}, SW'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 10), {$urandom, $urandom},
             $urandom_range(0, 3));
    end

    // Reset in the middle of a bus cycle
    @(negedge clk);
    s_cmd_adr = 37'h60;
    s_cmd_we = 1'b0;
    s_cmd_valid = 1'b1;
    guard = 0;
    while (!s_cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midbus_stb", {127'd0, m_wb_stb_o}, 128'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst", 128'({m_wb_stb_o, m_rsp_valid, s_cmd_ready, err_count}), 128'd0);
    model_errcnt = 0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_rst", 128'({s_cmd_ready, m_rsp_valid, m_wb_stb_o, err_count}),
          128'({1'b1, 1'b0, 1'b0, 2'd0}));

    // Error counter saturation
    for (int i = 0; i < 5; i++) begin
      do_cmd(AW'(i + 100), {$urandom, $urandom}, 8'hFF, 1'($urandom_range(0, 1)), TO + 2, 64'h0, 0);
    end
    check("err_sat", 128'(err_count), 128'(ERR_MAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
